// File: rtl/result_sink.sv
// result_sink
//   Pops one entry from a result FIFO and one from a status FIFO together,
//   holds the pair on out_result/out_status with out_valid, and retires it on
//   a valid/ready handshake. Every delivered pair updates three statistics:
//   a wrapping pair count, a saturating count of nonzero-status pairs and a
//   modulo-2^RESULT_WIDTH checksum of delivered results.
//
// Ports
//   clock                    single clock, all state on the rising edge
//   reset                    asynchronous, active-low reset
//   enable                   high permits starting a new FIFO read
//   result_empty/_data/_r_en result FIFO (one-cycle read latency)
//   status_empty/_data/_r_en status FIFO (one-cycle read latency)
//   out_valid/out_ready      handshake for the held pair
//   out_result/out_status    held pair
//   pair_count               pairs delivered, wrapping
//   error_count              delivered pairs with nonzero status, saturating
//   checksum                 sum of delivered results, carry discarded

module result_sink #(
    parameter int RESULT_WIDTH = 32,
    parameter int STATUS_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    result_empty,
    input  logic [RESULT_WIDTH-1:0] result_data,
    output logic                    result_r_en,
    input  logic                    status_empty,
    input  logic [STATUS_WIDTH-1:0] status_data,
    output logic                    status_r_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RESULT_WIDTH-1:0] out_result,
    output logic [STATUS_WIDTH-1:0] out_status,
    output logic [COUNT_WIDTH-1:0]  pair_count,
    output logic [COUNT_WIDTH-1:0]  error_count,
    output logic [RESULT_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_PRESENT
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_read;
    logic                    w_valid;
    logic                    w_handshake;

    logic [RESULT_WIDTH-1:0] r_out_result;
    logic [STATUS_WIDTH-1:0] r_out_status;
    logic [COUNT_WIDTH-1:0]  r_pair_count;
    logic [COUNT_WIDTH-1:0]  r_error_count;
    logic [RESULT_WIDTH-1:0] r_checksum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read enables and out_valid are decoded from the state register so
    // that an asynchronous reset drops them without waiting for a clock.
    always_comb begin
        w_next  = r_state;
        w_read  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !result_empty && !status_empty) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                w_read = 1'b1;
                w_next = S_LATCH;
            end
            S_LATCH: begin
                w_next = S_PRESENT;
            end
            S_PRESENT: begin
                w_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_handshake = w_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_result  <= '0;
            r_out_status  <= '0;
            r_pair_count  <= '0;
            r_error_count <= '0;
            r_checksum    <= '0;
        end else begin
            // FIFO data is valid the cycle after the pop, i.e. in LATCH.
            if (r_state == S_LATCH) begin
                r_out_result <= result_data;
                r_out_status <= status_data;
            end
            if (w_handshake) begin
                r_pair_count <= r_pair_count + COUNT_WIDTH'(1);
                r_checksum   <= r_checksum + r_out_result;
                if ((r_out_status != '0) && (r_error_count != '1)) begin
                    r_error_count <= r_error_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign result_r_en = w_read;
    assign status_r_en = w_read;
    assign out_valid   = w_valid;
    assign out_result  = r_out_result;
    assign out_status  = r_out_status;
    assign pair_count  = r_pair_count;
    assign error_count = r_error_count;
    assign checksum    = r_checksum;

endmodule

// File: doc/result_sink.md
RESULT_SINK -- requirements
Module: result_sink

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 32, width of result FIFO entries.
REQ-002 SHALL have parameter STATUS_WIDTH, default 8, width of status FIFO entries.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of pair_count and error_count.
REQ-004 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  high permits new FIFO reads.
REQ-007 SHALL have port result_empty  in  1  result FIFO empty flag.
REQ-008 SHALL have port result_data  in  RESULT_WIDTH  result FIFO read data.
REQ-009 SHALL have port result_r_en  out  1  result FIFO read enable.
REQ-010 SHALL have port status_empty  in  1  status FIFO empty flag.
REQ-011 SHALL have port status_data  in  STATUS_WIDTH  status FIFO read data.
REQ-012 SHALL have port status_r_en  out  1  status FIFO read enable.
REQ-013 SHALL have port out_valid  out  1  paired entry available.
REQ-014 SHALL have port out_ready  in  1  consumer accepts paired entry.
REQ-015 SHALL have port out_result  out  RESULT_WIDTH  held result value.
REQ-016 SHALL have port out_status  out  STATUS_WIDTH  held status value.
REQ-017 SHALL have port pair_count  out  COUNT_WIDTH  pairs delivered, wrapping.
REQ-018 SHALL have port error_count  out  COUNT_WIDTH  delivered pairs with nonzero status, saturating.
REQ-019 SHALL have port checksum  out  RESULT_WIDTH  modulo-2^RESULT_WIDTH sum of delivered results.

Function
REQ-020 SHALL implement FSM states IDLE, READ, LATCH, PRESENT.
REQ-021 IDLE -> READ SHALL occur only when enable=1, result_empty=0 and status_empty=0 in the same cycle; otherwise SHALL remain in IDLE.
REQ-022 In READ, result_r_en and status_r_en SHALL both be 1 for exactly one cycle; READ -> LATCH unconditionally.
REQ-023 r_en SHALL be 0 in every state other than READ; one FIFO SHALL never be read without the other.
REQ-024 FIFO read latency is one cycle: in LATCH, result_data and status_data SHALL be registered into out_result/out_status; LATCH -> PRESENT.
REQ-025 In PRESENT, out_valid SHALL be 1; out_result/out_status SHALL remain stable until the handshake.
REQ-026 Handshake completes on a rising edge with out_valid=1 and out_ready=1; PRESENT -> IDLE on that edge.
REQ-027 On handshake: pair_count += 1 (wraps all-ones -> 0); checksum += out_result (carry discarded); error_count += 1 if out_status != 0, holding at all-ones when saturated.
REQ-028 out_ready while not in PRESENT SHALL have no effect.
REQ-029 enable=0 SHALL block only IDLE -> READ; a transaction already in READ/LATCH/PRESENT SHALL complete normally.
REQ-030 Minimum spacing between handshakes SHALL be 4 cycles (IDLE, READ, LATCH, PRESENT).
REQ-031 Empty flags sampled in READ or later SHALL be ignored; empty-flag changes only matter in IDLE.
REQ-032 out_valid SHALL be 0 in IDLE, READ, LATCH; out_result/out_status SHALL retain the last latched values outside LATCH.

Reset
REQ-033 reset=0 SHALL immediately, independent of clock, force state IDLE, result_r_en=0, status_r_en=0, out_valid=0, out_result=0, out_status=0, pair_count=0, error_count=0, checksum=0.
REQ-034 Reset mid-transaction SHALL discard the in-flight pair; no counter update for it; FIFO entries already popped are lost.
REQ-035 First read after reset release SHALL occur no earlier than the second rising edge after reset returns to 1.

Verification
REQ-036 Single pair: result FIFO {0x0000_0007}, status FIFO {0x00}, out_ready=1 -> r_en pulse 1 cycle, out_valid one cycle later than LATCH, out_result=7, pair_count=1, checksum=7, error_count=0.
REQ-037 Back-pressure: 2 pairs {5,0x00},{9,0x03}, out_ready=0 for 6 cycles then 1 -> out_result stays 5, no second r_en until first handshake; final pair_count=2, checksum=14, error_count=1.
REQ-038 Asymmetric empty: result FIFO holds 3 entries, status FIFO empty for 10 cycles -> r_en never asserted; after one status write, exactly one pair read.
REQ-039 Wrap/saturate: preload via 2^COUNT_WIDTH+1 pairs with status 0x01, results 0xFFFF_FFFF -> pair_count=1, error_count=all-ones, checksum wraps per modulo rule.
REQ-040 Reset mid-operation: assert reset=0 during LATCH -> outputs zero asynchronously, counters 0, after release next available pair is read and delivered normally.
REQ-041 enable=0 while PRESENT -> current pair delivered on out_ready, no further reads until enable=1.
